ct_spsram_1024x64_ctrl: RTL
===========================

// Module: ct_spsram_1024x64_ctrl
// PURPOSE
//  Owns one 1024x64 single-port SRAM (ct_spsram_1024x64) and shares it between a read requester and a
//  masked-write requester. Sequences a full-array clear after reset and on request. Hides the macro's
//  active-low CEN/GWEN/WEN. Returns read data with a registered valid one cycle after grant.
// PARAMETERS
//  ADDR_WIDTH     10  SRAM address width; depth = 2**ADDR_WIDTH
//  DATA_WIDTH     64  data and bit-mask width
//  INIT_ON_RESET  1   1: clear sweep starts on reset release; 0: reset leaves the block idle
// PORTS
//  CLK         in   1           the single clock; drives the block and the SRAM
//  RST         in   1           asynchronous, active-high reset
//  inv_req     in   1           pulse: clear the whole array to 0
//  init_busy   out  1           clear sweep in progress; all grants forced to 0
//  rd_req      in   1           read request
//  rd_addr     in   ADDR_WIDTH  read address
//  rd_gnt      out  1           read accepted this cycle (combinational)
//  rd_vld      out  1           rd_data valid; registered, 1 cycle after rd_gnt
//  rd_data     out  DATA_WIDTH  read data; equals sram_q
//  wr_req      in   1           write request
//  wr_addr     in   ADDR_WIDTH  write address
//  wr_data     in   DATA_WIDTH  write data
//  wr_mask     in   DATA_WIDTH  active-high bit enable
//  wr_gnt      out  1           write accepted this cycle (combinational)
//  sram_a      out  ADDR_WIDTH  SRAM A
//  sram_cen    out  1           SRAM CEN, active low
//  sram_gwen   out  1           SRAM GWEN, active low (0 = write)
//  sram_wen    out  DATA_WIDTH  SRAM WEN, per-bit active low
//  sram_d      out  DATA_WIDTH  SRAM D
//  sram_q      in   DATA_WIDTH  SRAM Q
// BEHAVIOUR
//  - States: IDLE, INIT. Register init_cnt[ADDR_WIDTH-1:0]. Register rr_ptr: 0 = read has priority, 1 = write.
//  - Reset values: state = INIT if INIT_ON_RESET else IDLE; init_cnt = 0; rr_ptr = 0; rd_vld = 0.
//    Output state during reset: init_busy = INIT_ON_RESET, gnts = 0, sram_cen = 1.
//  - INIT, each cycle:
//    - Drive sram_cen = 0, sram_gwen = 0, sram_wen = all 0, sram_d = 0, sram_a = init_cnt.
//    - init_cnt += 1. At init_cnt == 2**ADDR_WIDTH-1, write that last entry and go to IDLE with init_cnt = 0.
//    - Sweep length is 1024 cycles exactly.
//  - IDLE, inv_req = 1: go to INIT next cycle. No grant that cycle; inv_req beats pending requests.
//  - INIT, inv_req = 1: ignored. The sweep continues; no restart.
//  - IDLE arbitration, only when !inv_req:
//    - Single requester: granted.
//    - Both requesting: rr_ptr side granted, then rr_ptr <= ~rr_ptr.
//    - rr_ptr changes only on a conflict.
//  - Read grant:
//    - Drive sram_cen = 0, sram_gwen = 1, sram_wen = all 1, sram_a = rd_addr.
//    - Next cycle rd_vld = 1 and rd_data = sram_q.
//  - Write grant:
//    - Drive sram_cen = 0, sram_gwen = 0, sram_wen = ~wr_mask, sram_a = wr_addr, sram_d = wr_data.
//    - wr_mask == 0 is still granted and is a harmless no-op access.
//  - No grant: sram_cen = 1, sram_gwen = 1, sram_wen = all 1. sram_a and sram_d hold 0.
//  - Requesters hold req/addr/data until their gnt; gnt is combinational from req in the same cycle.
//  - Read then write to the same address in back-to-back cycles returns the old data.
//    Write then read returns the new data; the SRAM serialises them.
//  - RST mid-sweep: async abort; sweep restarts from 0 on release (if INIT_ON_RESET). rd_vld clears immediately.
// STRUCTURE
//  - Shared header ct_spsram_ctrl_cfg.vh: state encodings (IDLE = 1'b0, INIT = 1'b1) and the default
//    ADDR_WIDTH/DATA_WIDTH.
//  - One sub-module, ct_spsram_ctrl_rr_arb: a 2-way round-robin with req[1:0], gnt[1:0], rr_ptr register
//    and an enable input (!init_busy && !inv_req).
//  - The SRAM macro is instanced by the parent, not inside this block.
// TESTING
//  1. Reset release, INIT_ON_RESET = 1:
//     - init_busy high for exactly 1024 cycles; sram_a sweeps 0..1023 with gwen = 0 and d = 0.
//     - rd_req held throughout: rd_gnt first rises on cycle 1025.
//  2. Write A=0x155, D=0xDEAD_BEEF_0123_4567, mask = all 1; next cycle read 0x155:
//     - rd_vld one cycle after rd_gnt with that data.
//  3. Masked write to 0x155, mask = 0x0000_0000_FFFF_0000, D = all 1; then read 0x155:
//     - Data 0xDEAD_BEEF_FFFF_4567; sram_wen = 0xFFFF_FFFF_0000_FFFF during the write.
//  4. rd_req and wr_req both held for 4 cycles after reset/init:
//     - Grants alternate R, W, R, W (rr_ptr starts 0); never both in one cycle.
//  5. inv_req while a read is pending in IDLE:
//     - No grant that cycle, 1024-cycle sweep follows.
//     - A read of 0x155 afterwards returns 0.
//     - A second inv_req mid-sweep does not extend the sweep.
//  6. Assert RST at sweep cycle 500:
//     - rd_vld = 0 and sram_cen = 1 immediately.
//     - On release the sweep restarts at address 0 and runs the full 1024 cycles.

Source files
------------

// File: rtl/ct_spsram_1024x64_ctrl_pkg.sv
// Shared definitions for the 1024x64 single-port SRAM controller:
// FSM state encodings and default geometry.
package ct_spsram_1024x64_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_t;

endpackage

// File: rtl/ct_spsram_1024x64_ctrl_rr_arb.sv
// Two-way round-robin arbiter: req[0] = read, req[1] = write.
// The pointer only moves when both sides collide in an enabled cycle.
module ct_spsram_1024x64_ctrl_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr_ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (&req) begin
                gnt = rr_ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (en && (&req)) begin
            rr_ptr <= ~rr_ptr;
        end
    end

endmodule

// File: rtl/ct_spsram_1024x64_ctrl.sv
// Shares one single-port SRAM between a read and a masked-write requester and
// sweeps the array to zero after reset or on request.
//   state   | meaning
//   IDLE    | arbitrating read/write requests
//   INIT    | clearing one entry per cycle at init_cnt, grants blocked
module ct_spsram_1024x64_ctrl
    import ct_spsram_1024x64_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  inv_req,
    output logic                  init_busy,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    output logic                  wr_gnt,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam state_t RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_IDLE;

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [1:0]            gnt;
    logic                  sweep;
    logic                  arb_en;

    assign init_busy = (state == ST_INIT);
    // RST gates the macro strobes so a held reset never touches the array.
    assign sweep     = init_busy && !RST;
    assign arb_en    = !init_busy && !inv_req && !RST;
    assign rd_gnt    = gnt[0];
    assign wr_gnt    = gnt[1];
    assign rd_data   = sram_q;

    ct_spsram_1024x64_ctrl_rr_arb u_rr_arb (
        .clk (CLK),
        .rst (RST),
        .en  (arb_en),
        .req ({wr_req, rd_req}),
        .gnt (gnt)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= RESET_STATE;
            init_cnt <= '0;
            rd_vld   <= 1'b0;
        end else begin
            rd_vld <= rd_gnt;
            if (state == ST_IDLE) begin
                if (inv_req) begin
                    state <= ST_INIT;
                end
            end else begin
                if (init_cnt == LAST_ADDR) begin
                    state    <= ST_IDLE;
                    init_cnt <= '0;
                end else begin
                    init_cnt <= init_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sram_a    = '0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_d    = '0;
        if (sweep) begin
            sram_a    = init_cnt;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
        end else if (rd_gnt) begin
            sram_a   = rd_addr;
            sram_cen = 1'b0;
        end else if (wr_gnt) begin
            sram_a    = wr_addr;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~wr_mask;
            sram_d    = wr_data;
        end
    end

endmodule
